seg_display_monitor: RTL and testbench

//  Receive end of the 14-bit two-digit seven-segment bus `s` driven by the FFinal top.

---
 rtl/seg_display_pkg.sv | 24 ++
 rtl/seg_display_monitor_if.sv | 23 ++
 rtl/seg_display_monitor_seg7_to_bcd.sv | 29 ++
 rtl/seg_display_monitor.sv | 117 +++++++++++
 tb/tb_seg_display_monitor.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/seg_display_pkg.sv
// Shared constants for the seven-segment display monitor: segment patterns, bus widths, FSM states.
// Pure declarations; no latency or flow control.
package seg_display_pkg;
  localparam int SEG_W = 7;
  localparam int BUS_W = 14;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_LOCKED = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;
endpackage

// File: rtl/seg_display_monitor_if.sv
// Segment bus into the monitor and its decoded status back out; slave is the monitor side.
// No handshake: s_in is sampled every cycle, status outputs are registered levels/pulses.
interface seg_display_monitor_if #(
  parameter int CNT_W = 8
);
  logic [seg_display_pkg::BUS_W-1:0] s_in;
  logic [3:0]                        val_tens;
  logic [3:0]                        val_ones;
  logic                              valid;
  logic                              locked;
  logic                              seg_err;
  logic [CNT_W-1:0]                  change_cnt;

  modport master (
    output s_in,
    input  val_tens, val_ones, valid, locked, seg_err, change_cnt
  );

  modport slave (
    input  s_in,
    output val_tens, val_ones, valid, locked, seg_err, change_cnt
  );
endinterface

// File: rtl/seg_display_monitor_seg7_to_bcd.sv
// Combinational seven-segment to BCD decoder with legality flag; zero latency.
// No flow control; blank_ok selects whether an all-dark field counts as a legal 0.
module seg7_to_bcd
  import seg_display_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  input  logic             blank_ok,
  output logic [3:0]       bcd,
  output logic             legal
);
  always_comb begin
    bcd   = 4'd0;
    legal = 1'b1;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: legal = blank_ok;
      default:   legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/seg_display_monitor.sv
// Debounces the two-digit segment bus and reports locked BCD value; outputs update the cycle after the STABLE_CYCLES-th matching sample.
// No backpressure: every edge samples s_in, results are registered pulses/levels.
module seg_display_monitor
  import seg_display_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
)(
  input  logic                  clk,
  input  logic                  rst,
  seg_display_monitor_if.slave  bus
);
  localparam int              RUN_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

  state_t           state;
  logic [BUS_W-1:0] s_q;
  logic [RUN_W-1:0] run_len;
  logic [RUN_W-1:0] run_nxt;
  logic             diff;
  logic             stable;
  logic [3:0]       tens_bcd, ones_bcd;
  logic             tens_legal, ones_legal;
  logic [3:0]       val_tens_q, val_ones_q;
  logic             valid_q, locked_q, seg_err_q, have_prev;
  logic [CNT_W-1:0] cnt_q;

  // run_len of zero marks the first edge after reset.
  always_comb begin
    diff = (bus.s_in != s_q);
    if (run_len == '0 || diff)
      run_nxt = RUN_W'(1);
    else if (run_len >= RUN_MAX)
      run_nxt = RUN_MAX;
    else
      run_nxt = run_len + RUN_W'(1);
    stable = (run_nxt == RUN_MAX);
  end

  // At a stable edge s_q equals s_in, so decoding the registered copy is equivalent.
  seg7_to_bcd u_tens (
    .seg      (s_q[BUS_W-1:SEG_W]),
    .blank_ok (1'b1),
    .bcd      (tens_bcd),
    .legal    (tens_legal)
  );

  seg7_to_bcd u_ones (
    .seg      (s_q[SEG_W-1:0]),
    .blank_ok (1'b0),
    .bcd      (ones_bcd),
    .legal    (ones_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_SETTLE;
      s_q        <= '0;
      run_len    <= '0;
      have_prev  <= 1'b0;
      val_tens_q <= 4'd0;
      val_ones_q <= 4'd0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      seg_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s_q     <= bus.s_in;
      run_len <= run_nxt;
      valid_q <= 1'b0;
      case (state)
        ST_SETTLE: begin
          if (stable) begin
            if (tens_legal && ones_legal) begin
              state      <= ST_LOCKED;
              locked_q   <= 1'b1;
              valid_q    <= 1'b1;
              val_tens_q <= tens_bcd;
              val_ones_q <= ones_bcd;
              have_prev  <= 1'b1;
              if ((!have_prev || {tens_bcd, ones_bcd} != {val_tens_q, val_ones_q})
                  && cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
              state     <= ST_ERROR;
              seg_err_q <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (diff) begin
            state    <= ST_SETTLE;
            locked_q <= 1'b0;
          end
        end
        ST_ERROR: begin
          if (diff) begin
            state     <= ST_SETTLE;
            seg_err_q <= 1'b0;
          end
        end
        default: begin
          state     <= ST_SETTLE;
          locked_q  <= 1'b0;
          seg_err_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.val_tens   = val_tens_q;
  assign bus.val_ones   = val_ones_q;
  assign bus.valid      = valid_q;
  assign bus.locked     = locked_q;
  assign bus.seg_err    = seg_err_q;
  assign bus.change_cnt = cnt_q;
endmodule

// File: tb/tb_seg_display_monitor.sv
// Directed plus random stimulus for seg_display_monitor, checked every edge against a run-length reference model.
module tb_seg_display_monitor;
  localparam int STABLE = 4;
  localparam int CNTW   = 8;
  localparam int CMAX   = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_display_monitor_if #(.CNT_W(CNTW)) bus ();

  seg_display_monitor #(.STABLE_CYCLES(STABLE), .CNT_W(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [6:0] pats [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  int tests = 0;
  int fails = 0;

  // reference model state
  bit          m_first;
  bit          m_decided;
  bit          m_have_prev;
  int          m_run;
  logic [13:0] m_last;
  int          e_tens, e_ones, e_cnt;
  bit          e_valid, e_locked, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit find_digit(input logic [6:0] f, output int d);
    d = 0;
    for (int i = 0; i < 10; i++)
      if (pats[i] == f) begin
        d = i;
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_first = 1; m_decided = 0; m_have_prev = 0; m_run = 0; m_last = '0;
    e_tens = 0; e_ones = 0; e_cnt = 0; e_valid = 0; e_locked = 0; e_err = 0;
  endtask

  task automatic model_edge(input logic [13:0] s);
    int  t, o;
    bit  tl, ol;
    if (m_first || s != m_last) begin
      m_run = 1; m_decided = 0; e_locked = 0; e_err = 0;
    end else begin
      m_run++;
    end
    m_last = s; m_first = 0; e_valid = 0;
    if (!m_decided && m_run >= STABLE) begin
      m_decided = 1;
      if (s[13:7] == 7'b0) begin tl = 1; t = 0; end
      else tl = find_digit(s[13:7], t);
      ol = find_digit(s[6:0], o);
      if (tl && ol) begin
        e_valid = 1; e_locked = 1;
        if (!m_have_prev || t != e_tens || o != e_ones)
          e_cnt = (e_cnt < CMAX) ? e_cnt + 1 : CMAX;
        e_tens = t; e_ones = o; m_have_prev = 1;
      end else begin
        e_err = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".val_tens"},   32'(bus.val_tens),   32'(e_tens));
    chk({tag, ".val_ones"},   32'(bus.val_ones),   32'(e_ones));
    chk({tag, ".valid"},      32'(bus.valid),      32'(e_valid));
    chk({tag, ".locked"},     32'(bus.locked),     32'(e_locked));
    chk({tag, ".seg_err"},    32'(bus.seg_err),    32'(e_err));
    chk({tag, ".change_cnt"}, 32'(bus.change_cnt), 32'(e_cnt));
  endtask

  task automatic step(input string tag, input logic [13:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      bus.s_in = s;
      @(posedge clk);
      model_edge(s);
      #1;
      check_all(tag);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    check_all(tag);
    rst = 1'b0;
  endtask

  function automatic logic [13:0] num(input int t, input int o);
    return {pats[t], pats[o]};
  endfunction

  initial begin
    logic [13:0] p;
    int          r, len;
    bus.s_in = '0;
    model_reset();
    do_reset("reset");
    do_reset("reset2");
    chk("reset.cnt_zero", 32'(bus.change_cnt), 32'd0);

    // 1: first lock of 42
    step("t1", 14'b0110011_1101101, STABLE);
    chk("t1.valid", 32'(bus.valid), 32'd1);
    chk("t1.tens", 32'(bus.val_tens), 32'd4);
    chk("t1.ones", 32'(bus.val_ones), 32'd2);
    chk("t1.locked", 32'(bus.locked), 32'd1);
    chk("t1.cnt", 32'(bus.change_cnt), 32'd1);
    step("t1b", num(4, 2), 1);
    chk("t1.valid_1cyc", 32'(bus.valid), 32'd0);

    // 2: short 41 then 43 held
    step("t2a", num(4, 1), 2);
    step("t2b", num(4, 3), STABLE);
    chk("t2.tens", 32'(bus.val_tens), 32'd4);
    chk("t2.ones", 32'(bus.val_ones), 32'd3);
    chk("t2.cnt", 32'(bus.change_cnt), 32'd2);

    // 3: illegal ones field
    step("t3a", {pats[4], 7'b0000001}, STABLE);
    chk("t3.err", 32'(bus.seg_err), 32'd1);
    chk("t3.locked", 32'(bus.locked), 32'd0);
    chk("t3.valid", 32'(bus.valid), 32'd0);
    chk("t3.ones_kept", 32'(bus.val_ones), 32'd3);
    step("t3b", num(4, 3), 1);
    chk("t3.err_clear", 32'(bus.seg_err), 32'd0);
    step("t3c", num(4, 3), STABLE - 1);

    // 4: one-edge glitch, relock same value
    step("t4a", num(4, 8), 1);
    step("t4b", num(4, 3), STABLE);
    chk("t4.valid", 32'(bus.valid), 32'd1);
    chk("t4.cnt", 32'(bus.change_cnt), 32'd2);

    // 5: blank tens legal, blank ones illegal
    step("t5a", {7'b0000000, pats[7]}, STABLE);
    chk("t5.tens", 32'(bus.val_tens), 32'd0);
    chk("t5.ones", 32'(bus.val_ones), 32'd7);
    step("t5b", {pats[4], 7'b0000000}, STABLE);
    chk("t5.err", 32'(bus.seg_err), 32'd1);

    // random patterns with random hold lengths
    for (int i = 0; i < 80; i++) begin
      r   = int'($urandom_range(0, 9));
      len = int'($urandom_range(1, 6));
      if (r < 7)
        p = num(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
      else if (r == 7)
        p = {7'b0, pats[$urandom_range(0, 9)]};
      else
        p = 14'($urandom);
      step("rand", p, len);
    end

    // 6: alternating values saturate change_cnt
    for (int i = 0; i < 150; i++) begin
      step("t6a", num(1, 2), STABLE);
      step("t6b", num(2, 1), STABLE);
    end
    chk("t6.cnt_sat", 32'(bus.change_cnt), 32'(CMAX));

    // reset in the middle of settling
    step("t7a", num(1, 2), 2);
    do_reset("t7.rst");
    chk("t7.tens", 32'(bus.val_tens), 32'd0);
    chk("t7.cnt", 32'(bus.change_cnt), 32'd0);
    chk("t7.locked", 32'(bus.locked), 32'd0);
    step("t7b", num(9, 9), STABLE);
    chk("t7.relock_cnt", 32'(bus.change_cnt), 32'd1);
    chk("t7.relock_tens", 32'(bus.val_tens), 32'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
